// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: scheduler state encoding,
// default watchdog limit and the UART register map.
package uart_defs;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } sched_state_t;

   localparam logic [15:0] DEF_TIMEOUT = 16'd50000;

   localparam logic [7:0] UART_REG_DATA   = 8'h00;
   localparam logic [7:0] UART_REG_STATUS = 8'h04;
   localparam logic [7:0] UART_REG_CTRL   = 8'h08;
   localparam logic [7:0] UART_REG_COUNT  = 8'h0C;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin selector for the TX scheduler.
// Prefers the requester that was not granted last.
module uart_rr_arb2 (
   input  logic full0,
   input  logic full1,
   input  logic last,
   output logic gnt_valid,
   output logic gnt_id
);

   assign gnt_valid = full0 | full1;
   assign gnt_id    = (full0 & full1) ? ~last : full1;

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester byte scheduler in front of a UART transmitter,
// with one-entry holding buffers and a TX completion watchdog.
module uart_tx_sched
   import uart_defs::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TO_W    = 16,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sched_en,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              tx_busy,
   input  logic              tx_done,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data,
   output logic              grant_id,
   output logic              busy,
   output logic              to_err,
   input  logic              err_clr,
   output logic [15:0]       tx_count
);

   sched_state_t      r_state;
   sched_state_t      w_next;
   logic              r_full0;
   logic              r_full1;
   logic [DATA_W-1:0] r_data0;
   logic [DATA_W-1:0] r_data1;
   logic              r_last;
   logic              r_grant_id;
   logic [TO_W-1:0]   r_wd;
   logic              r_to_err;
   logic [15:0]       r_tx_count;

   logic w_gnt_valid;
   logic w_gnt_id;
   logic w_acc0;
   logic w_acc1;
   logic w_done;
   logic w_to;
   logic w_fin;
   logic w_grant;
   logic w_tx_start;
   logic w_busy;

   uart_rr_arb2 u_arb (
      .full0     (r_full0),
      .full1     (r_full1),
      .last      (r_last),
      .gnt_valid (w_gnt_valid),
      .gnt_id    (w_gnt_id)
   );

   assign w_acc0  = req0_valid & ~r_full0;
   assign w_acc1  = req1_valid & ~r_full1;
   assign w_done  = (r_state == ST_WAIT) & tx_done;
   // done in the last watchdog cycle counts as success
   assign w_to    = (r_state == ST_WAIT) & ~tx_done
                  & (r_wd == TO_W'(TIMEOUT - 1));
   assign w_fin   = w_done | w_to;
   assign w_grant = (r_state == ST_IDLE) & (w_next == ST_START);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (sched_en & w_gnt_valid) w_next = ST_START;
         ST_START: if (~tx_busy) w_next = ST_WAIT;
         ST_WAIT:  if (w_fin) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_tx_start = (r_state == ST_START) & ~tx_busy;
      w_busy     = (r_state != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full0 <= 1'b0;
         r_data0 <= '0;
      end else if (w_acc0) begin
         r_full0 <= 1'b1;
         r_data0 <= req0_data;
      end else if (w_fin & ~r_grant_id) begin
         r_full0 <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full1 <= 1'b0;
         r_data1 <= '0;
      end else if (w_acc1) begin
         r_full1 <= 1'b1;
         r_data1 <= req1_data;
      end else if (w_fin & r_grant_id) begin
         r_full1 <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant_id <= 1'b0;
         r_last     <= 1'b1;
      end else begin
         if (w_grant) r_grant_id <= w_gnt_id;
         if (w_fin)   r_last     <= r_grant_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wd <= '0;
      end else if (r_state == ST_WAIT) begin
         r_wd <= r_wd + TO_W'(1);
      end else begin
         r_wd <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_err   <= 1'b0;
         r_tx_count <= 16'd0;
      end else begin
         if (w_to)         r_to_err <= 1'b1;
         else if (err_clr) r_to_err <= 1'b0;
         if (w_done) r_tx_count <= r_tx_count + 16'd1;
      end
   end

   assign req0_ready = ~r_full0;
   assign req1_ready = ~r_full1;
   assign tx_start   = w_tx_start;
   assign tx_data    = r_grant_id ? r_data1 : r_data0;
   assign grant_id   = r_grant_id;
   assign busy       = w_busy;
   assign to_err     = r_to_err;
   assign tx_count   = r_tx_count;

endmodule
